// File: rtl/ue14500_pkg.sv
// ---------------------------------------------------------------------------
// ue14500_pkg
// Shared definitions for the 1-bit ICU tile: the 4-bit opcode set (shared
// with the ICU core), default sequencer geometry and the sequencer state
// encoding.
// ---------------------------------------------------------------------------
package ue14500_pkg;

   // Default program address width and return stack depth.
   localparam int unsigned AW_DEF    = 8;
   localparam int unsigned DEPTH_DEF = 4;

   // ICU opcode nibbles.
   typedef enum logic [3:0] {
      OpNop0 = 4'h0,
      OpLd   = 4'h1,
      OpLdc  = 4'h2,
      OpAnd  = 4'h3,
      OpAndc = 4'h4,
      OpOr   = 4'h5,
      OpOrc  = 4'h6,
      OpXnor = 4'h7,
      OpSto  = 4'h8,
      OpStoc = 4'h9,
      OpIen  = 4'hA,
      OpOen  = 4'hB,
      OpJmp  = 4'hC,
      OpRtn  = 4'hD,
      OpSkz  = 4'hE,
      OpNopf = 4'hF
   } opcode_e;

   // Sequencer states.
   typedef enum logic [0:0] {
      StRun  = 1'b0,
      StHalt = 1'b1
   } seq_state_e;

endpackage

// File: rtl/ue14500_seq_if.sv
// ---------------------------------------------------------------------------
// ue14500_seq_if
// Bundle between the program sequencer, program memory and the ICU.
//   OPC_IN/TGT_IN : word at PC from program memory
//   JMP/RTN/FL0/FLF : registered ICU pulses
//   RUN           : resume request while halted
//   PC/OPC_OUT    : fetch address and opcode forwarded to the ICU
//   HALTED/STK_ERR: status
// Modports: slave = sequencer, master = memory/ICU side (or a testbench).
// ---------------------------------------------------------------------------
interface ue14500_seq_if
   import ue14500_pkg::*;
#(
   parameter int unsigned AW = AW_DEF
);
   logic [3:0]    OPC_IN;
   logic [AW-1:0] TGT_IN;
   logic          JMP;
   logic          RTN;
   logic          FL0;
   logic          FLF;
   logic          RUN;
   logic [AW-1:0] PC;
   logic [3:0]    OPC_OUT;
   logic          HALTED;
   logic          STK_ERR;

   modport master (
      output OPC_IN, TGT_IN, JMP, RTN, FL0, FLF, RUN,
      input  PC, OPC_OUT, HALTED, STK_ERR
   );

   modport slave (
      input  OPC_IN, TGT_IN, JMP, RTN, FL0, FLF, RUN,
      output PC, OPC_OUT, HALTED, STK_ERR
   );
endinterface

// File: rtl/ue14500_rstack.sv
// ---------------------------------------------------------------------------
// ue14500_rstack
// Return address stack, DEPTH entries of AW bits.
//   CLK, RST_N : clock, async active-low reset (clears SP only)
//   push_i     : push din_i; when full the top entry is overwritten
//   pop_i      : pop; has priority over push_i
//   top_o      : entry at SP-1 (don't-care when empty)
//   empty_o    : SP == 0
//   ovf_o      : push while full (strobe)
//   unf_o      : pop while empty (strobe)
// ---------------------------------------------------------------------------
module ue14500_rstack #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [AW-1:0] din_i,
   output logic [AW-1:0] top_o,
   output logic          empty_o,
   output logic          ovf_o,
   output logic          unf_o
);
   localparam int unsigned IW  = $clog2(DEPTH);
   localparam int unsigned SPW = IW + 1;

   logic [AW-1:0]  mem_q [DEPTH];
   logic [SPW-1:0] sp_q;
   logic           full;
   logic           do_push;
   logic [IW-1:0]  top_idx;
   logic [IW-1:0]  wr_idx;

   assign full    = (sp_q == SPW'(DEPTH));
   assign empty_o = (sp_q == '0);
   assign do_push = push_i & ~pop_i;
   assign top_idx = IW'(sp_q - 1'b1);
   // A push into a full stack lands on the top slot instead of growing.
   assign wr_idx  = full ? IW'(DEPTH - 1) : IW'(sp_q);

   assign top_o = mem_q[top_idx];
   assign ovf_o = do_push & full;
   assign unf_o = pop_i & empty_o;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sp_q <= '0;
      end else if (pop_i) begin
         if (!empty_o) sp_q <= sp_q - 1'b1;
      end else if (do_push && !full) begin
         sp_q <= sp_q + 1'b1;
      end
   end

   // Contents need no reset.
   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_idx] <= din_i;
   end

endmodule

// File: rtl/ue14500_seq.sv
// ---------------------------------------------------------------------------
// ue14500_seq
// Program sequencer for the 1-bit ICU. Owns PC, forwards the opcode nibble
// and reacts to the ICU's registered JMP/RTN/FL0/FLF pulses with jump,
// FL0-armed call, return and halt. Return addresses live in ue14500_rstack.
//   CLK, RST_N : clock, async active-low reset
//   bus        : ue14500_seq_if.slave (OPC_IN, TGT_IN, JMP, RTN, FL0, FLF,
//                RUN in; PC, OPC_OUT, HALTED, STK_ERR out)
// Optional build macro UE14500_SEQ_SQUASH_EN: hides the jump delay slot by
// forcing OPC_OUT to NOPF during the JMP pulse and ignoring the FLF pulse
// that this produces one cycle later.
// ---------------------------------------------------------------------------
module ue14500_seq
   import ue14500_pkg::*;
#(
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input logic          CLK,
   input logic          RST_N,
   ue14500_seq_if.slave bus
);
   seq_state_e    state_q;
   logic [AW-1:0] pc_q;
   logic [AW-1:0] tgt_q;
   logic          call_arm_q;
   logic          stk_err_q;

   logic          run_st;
   logic          stk_push;
   logic          stk_pop;
   logic [AW-1:0] stk_top;
   logic          stk_empty;
   logic          stk_ovf;
   logic          stk_unf;
   logic          flf_eff;

`ifdef UE14500_SEQ_SQUASH_EN
   // Set for the cycle after a taken JMP; that cycle's FLF came from the
   // squashed delay slot.
   logic squash_q;
   assign flf_eff = bus.FLF & ~squash_q;
`else
   assign flf_eff = bus.FLF;
`endif

   assign run_st   = (state_q == StRun);
   // RTN outranks JMP, so a simultaneous pair only ever pops.
   assign stk_pop  = run_st & bus.RTN;
   assign stk_push = run_st & ~bus.RTN & bus.JMP & call_arm_q;

   ue14500_rstack #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_rstack (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .push_i  (stk_push),
      .pop_i   (stk_pop),
      .din_i   (pc_q + 1'b1),
      .top_o   (stk_top),
      .empty_o (stk_empty),
      .ovf_o   (stk_ovf),
      .unf_o   (stk_unf)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= StRun;
         pc_q       <= '0;
         tgt_q      <= '0;
         call_arm_q <= 1'b0;
         stk_err_q  <= 1'b0;
`ifdef UE14500_SEQ_SQUASH_EN
         squash_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StRun: begin
               // Captured every cycle so it holds the JMP word's target
               // during the pulse cycle that follows.
               tgt_q <= bus.TGT_IN;
               if (bus.RTN) begin
                  pc_q       <= stk_empty ? '0 : stk_top;
                  call_arm_q <= 1'b0;
               end else if (bus.JMP) begin
                  pc_q       <= tgt_q;
                  call_arm_q <= 1'b0;
               end else begin
                  pc_q <= pc_q + 1'b1;
                  if (flf_eff) state_q <= StHalt;
                  if (bus.FL0) call_arm_q <= 1'b1;
               end
`ifdef UE14500_SEQ_SQUASH_EN
               squash_q <= bus.JMP & ~bus.RTN;
`endif
            end
            StHalt: begin
               if (bus.RUN) state_q <= StRun;
`ifdef UE14500_SEQ_SQUASH_EN
               squash_q <= 1'b0;
`endif
            end
         endcase
         if (stk_ovf || stk_unf) stk_err_q <= 1'b1;
      end
   end

   always_comb begin
      bus.OPC_OUT = bus.OPC_IN;
      if (state_q == StHalt) begin
         bus.OPC_OUT = OpNopf;
      end
`ifdef UE14500_SEQ_SQUASH_EN
      else if (bus.JMP) begin
         bus.OPC_OUT = OpNopf;
      end
`endif
   end

   assign bus.PC      = pc_q;
   assign bus.HALTED  = (state_q == StHalt);
   assign bus.STK_ERR = stk_err_q;

endmodule

// File: tb/tb_ue14500_seq.sv
// ---------------------------------------------------------------------------
// tb_ue14500_seq
// Directed bench for ue14500_seq with a queue-based reference model checked
// every cycle, plus hand-computed checkpoints. The bench plays the role of
// program memory and the ICU by driving words and pulses directly.
// ---------------------------------------------------------------------------
module tb_ue14500_seq;
   import ue14500_pkg::*;

   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 4;
`ifdef UE14500_SEQ_SQUASH_EN
   localparam bit SQ = 1'b1;
`else
   localparam bit SQ = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ue14500_seq_if #(.AW(AW)) bus ();

   ue14500_seq #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [AW-1:0] m_pc;
   logic [AW-1:0] m_tgt;
   logic [AW-1:0] m_old_tgt;
   logic [AW-1:0] m_stk[$];
   bit            m_halt, m_arm, m_err, m_sqz, m_flf_ok;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc = '0; m_tgt = '0; m_halt = 0; m_arm = 0; m_err = 0; m_sqz = 0;
         m_stk.delete();
      end else if (m_halt) begin
         if (bus.RUN) m_halt = 0;
         m_sqz = 0;
      end else begin
         m_old_tgt = m_tgt;
         m_tgt     = bus.TGT_IN;
         m_flf_ok  = bus.FLF && !m_sqz;
         m_sqz     = SQ && bus.JMP && !bus.RTN;
         if (bus.RTN) begin
            if (m_stk.size() == 0) begin
               m_pc  = '0;
               m_err = 1;
            end else begin
               m_pc = m_stk.pop_back();
            end
            m_arm = 0;
         end else if (bus.JMP) begin
            if (m_arm) begin
               if (m_stk.size() == DEPTH) begin
                  m_stk[DEPTH-1] = m_pc + 8'd1;
                  m_err = 1;
               end else begin
                  m_stk.push_back(m_pc + 8'd1);
               end
            end
            m_pc  = m_old_tgt;
            m_arm = 0;
         end else begin
            m_pc = m_pc + 8'd1;
            if (m_flf_ok) m_halt = 1;
            if (bus.FL0) m_arm = 1;
         end
      end
   end

   // Cycle-by-cycle compare, away from the active edge.
   logic [3:0] exp_opc;
   always @(negedge clk) begin
      if (rst_n) begin
         exp_opc = m_halt ? 4'hF : ((SQ && bus.JMP) ? 4'hF : bus.OPC_IN);
         chk("pc", 32'(bus.PC), 32'(m_pc));
         chk("opc_out", 32'(bus.OPC_OUT), 32'(exp_opc));
         chk("halted", 32'(bus.HALTED), 32'(m_halt));
         chk("stk_err", 32'(bus.STK_ERR), 32'(m_err));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      bus.OPC_IN = 4'h2;
      bus.TGT_IN = '0;
      bus.JMP = 0; bus.RTN = 0; bus.FL0 = 0; bus.FLF = 0; bus.RUN = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Leaves PC = 0 at posedge+2; n further ticks give PC = n.
   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   logic [AW-1:0] pops [5];

   initial begin
      idle();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_pc", 32'(bus.PC), 32'h0);
      chk("rst_halted", 32'(bus.HALTED), 32'h0);
      chk("rst_stk_err", 32'(bus.STK_ERR), 32'h0);
      chk("rst_opc", 32'(bus.OPC_OUT), 32'h2);
      tick();
      rst_n = 1'b1;

      // Free run with wrap.
      for (int k = 0; k < 255; k++) tick();
      chk("run_pc255", 32'(bus.PC), 32'hFF);
      tick();
      chk("run_wrap", 32'(bus.PC), 32'h0);

      // Plain jump at 5 -> 0x40 with delay slot at 6.
      do_reset();
      for (int k = 0; k < 5; k++) tick();
      bus.OPC_IN = OpJmp; bus.TGT_IN = 8'h40;
      tick();
      chk("jmp_slot_pc", 32'(bus.PC), 32'h6);
      idle(); bus.JMP = 1;
      #1 chk("jmp_slot_opc", 32'(bus.OPC_OUT), SQ ? 32'hF : 32'h2);
      tick();
      chk("jmp_target", 32'(bus.PC), 32'h40);
      idle(); bus.FLF = SQ;  // a squashed slot makes the ICU pulse FLF
      tick();
      chk("jmp_no_halt", 32'(bus.HALTED), 32'h0);
      chk("jmp_after", 32'(bus.PC), 32'h41);

      // Call: NOP0 at 3, JMP 0x20 at 4, RTN at 0x22.
      do_reset();
      for (int k = 0; k < 3; k++) tick();
      bus.OPC_IN = OpNop0;
      tick();
      bus.OPC_IN = OpJmp; bus.TGT_IN = 8'h20; bus.FL0 = 1;
      tick();
      idle(); bus.JMP = 1;
      tick();
      chk("call_target", 32'(bus.PC), 32'h20);
      idle();
      tick(); tick();
      chk("call_rtn_word", 32'(bus.PC), 32'h22);
      bus.OPC_IN = OpRtn;
      tick();
      idle(); bus.RTN = 1;
      tick();
      chk("call_return", 32'(bus.PC), 32'h6);
      chk("call_no_err", 32'(bus.STK_ERR), 32'h0);
      // Stack must be empty again: another RTN underflows.
      tick();
      chk("call_sp0_pc", 32'(bus.PC), 32'h0);
      chk("call_sp0_err", 32'(bus.STK_ERR), 32'h1);
      idle();

      // Halt via NOPF at 10.
      do_reset();
      for (int k = 0; k < 10; k++) tick();
      bus.OPC_IN = OpNopf;
      tick();
      idle(); bus.FLF = 1;
      tick();
      for (int i = 0; i < 5; i++) begin
         bus.JMP = 1; bus.FLF = 1; bus.FL0 = 1; bus.RTN = i[0];
         chk("halt_pc", 32'(bus.PC), 32'hC);
         chk("halt_flag", 32'(bus.HALTED), 32'h1);
         chk("halt_opc", 32'(bus.OPC_OUT), 32'hF);
         tick();
      end
      idle(); bus.RUN = 1;
      tick();
      chk("resume_pc", 32'(bus.PC), 32'hC);
      chk("resume_flag", 32'(bus.HALTED), 32'h0);
      idle();
      tick();
      chk("resume_13", 32'(bus.PC), 32'hD);
      tick();
      chk("resume_14", 32'(bus.PC), 32'hE);

      // Five nested calls into a 4-deep stack, then five returns.
      do_reset();
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         bus.FL0 = 1; bus.TGT_IN = AW'(8'h10 * (i + 1));
         tick();
         bus.FL0 = 0; bus.TGT_IN = '0; bus.JMP = 1;
         tick();
         idle();
         chk("nest_target", 32'(bus.PC), 32'(8'h10 * (i + 1)));
         if (i == 3) chk("nest_err_pre", 32'(bus.STK_ERR), 32'h0);
      end
      chk("nest_err_ovf", 32'(bus.STK_ERR), 32'h1);
      pops = '{8'h42, 8'h22, 8'h12, 8'h04, 8'h00};
      for (int i = 0; i < 5; i++) begin
         bus.RTN = 1;
         tick();
         chk("nest_pop", 32'(bus.PC), 32'(pops[i]));
      end
      idle();
      chk("nest_err_sticky", 32'(bus.STK_ERR), 32'h1);

      // Reset asserted during an armed JMP pulse.
      do_reset();
      for (int k = 0; k < 4; k++) tick();
      bus.FL0 = 1;
      tick();
      bus.FL0 = 0; bus.OPC_IN = OpJmp; bus.TGT_IN = 8'h40;
      tick();
      idle(); bus.JMP = 1;
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_pc", 32'(bus.PC), 32'h0);
      chk("mid_rst_halted", 32'(bus.HALTED), 32'h0);
      chk("mid_rst_err", 32'(bus.STK_ERR), 32'h0);
      tick();
      idle();
      rst_n = 1'b1;
      // Armed call was lost and SP is 0: jump then return underflows.
      bus.OPC_IN = OpJmp; bus.TGT_IN = 8'h30;
      tick();
      idle(); bus.JMP = 1;
      tick();
      chk("post_rst_jmp", 32'(bus.PC), 32'h30);
      idle(); bus.RTN = 1;
      tick();
      chk("post_rst_rtn", 32'(bus.PC), 32'h0);
      chk("post_rst_unf", 32'(bus.STK_ERR), 32'h1);
      idle();
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
